vx_mem_axi_read_bridge: RTL and testbench

VX_MEM_AXI_READ_BRIDGE -- requirements
Module: VX_mem_axi_read_bridge

---
 rtl/vx_mem_axi_read_bridge.sv | 150 +++++++++++++++
 tb/tb_vx_mem_axi_read_bridge.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_axi_read_bridge.sv
// vx_mem_axi_read_bridge
//   Converts a word-addressed read request/response stream into single-beat
//   AXI4 read transactions.
//   Requests are captured into a one-entry AR holding register. Responses on R
//   are passed straight through to the mem_rsp stream. An outstanding-read
//   counter limits the number of reads in flight to MAX_PENDING.
//
// Ports
//   clk, reset                      single clock, synchronous active-high reset
//   mem_req_*                       read requests (addr is a line address)
//   mem_rsp_*                       read responses (combinational from R)
//   m_axi_ar*                       AXI AR master channel
//   m_axi_r*                        AXI R channel
//   pending_count, busy, rsp_error  status; rsp_error is sticky until reset
module vx_mem_axi_read_bridge #(
  parameter int DATA_WIDTH  = 512,
  parameter int ADDR_WIDTH  = 26,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 8
) (
  input  logic                                         clk,
  input  logic                                         reset,

  input  logic                                         mem_req_valid,
  output logic                                         mem_req_ready,
  input  logic [ADDR_WIDTH-1:0]                        mem_req_addr,
  input  logic [TAG_WIDTH-1:0]                         mem_req_tag,

  output logic                                         mem_rsp_valid,
  input  logic                                         mem_rsp_ready,
  output logic [DATA_WIDTH-1:0]                        mem_rsp_data,
  output logic [TAG_WIDTH-1:0]                         mem_rsp_tag,

  output logic                                         m_axi_arvalid,
  input  logic                                         m_axi_arready,
  output logic [ADDR_WIDTH+$clog2(DATA_WIDTH/8)-1:0]   m_axi_araddr,
  output logic [TAG_WIDTH-1:0]                         m_axi_arid,
  output logic [7:0]                                   m_axi_arlen,
  output logic [2:0]                                   m_axi_arsize,
  output logic [1:0]                                   m_axi_arburst,
  output logic [1:0]                                   m_axi_arlock,
  output logic [3:0]                                   m_axi_arcache,
  output logic [2:0]                                   m_axi_arprot,
  output logic [3:0]                                   m_axi_arqos,
  output logic [3:0]                                   m_axi_arregion,

  input  logic                                         m_axi_rvalid,
  output logic                                         m_axi_rready,
  input  logic [DATA_WIDTH-1:0]                        m_axi_rdata,
  input  logic                                         m_axi_rlast,
  input  logic [TAG_WIDTH-1:0]                         m_axi_rid,
  input  logic [1:0]                                   m_axi_rresp,

  output logic [$clog2(MAX_PENDING+1)-1:0]             pending_count,
  output logic                                         busy,
  output logic                                         rsp_error
);

  localparam int OFFS_BITS = $clog2(DATA_WIDTH/8);
  localparam int CNT_WIDTH = $clog2(MAX_PENDING+1);
  localparam int AXI_AW    = ADDR_WIDTH + OFFS_BITS;

  logic                  ar_valid_q, ar_valid_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q,  ar_addr_d;
  logic [TAG_WIDTH-1:0]  ar_tag_q,   ar_tag_d;
  logic [CNT_WIDTH-1:0]  pending_q,  pending_d;
  logic                  error_q,    error_d;

  logic req_fire;
  logic r_fire;
  logic retire;

  // Ready uses the registered count only, so a full bridge stays stalled for
  // the whole cycle in which a response retires.
  assign mem_req_ready = (!ar_valid_q || m_axi_arready)
                      && (pending_q < CNT_WIDTH'(MAX_PENDING));

  assign req_fire = mem_req_valid && mem_req_ready;
  assign r_fire   = m_axi_rvalid && mem_rsp_ready;
  // A beat arriving with nothing outstanding must not wrap the counter.
  assign retire   = r_fire && m_axi_rlast && (pending_q != '0);

  always_comb begin
    ar_valid_d = ar_valid_q;
    ar_addr_d  = ar_addr_q;
    ar_tag_d   = ar_tag_q;
    pending_d  = pending_q;
    error_d    = error_q;

    // A new acceptance reloads the register even while the old entry is
    // leaving, giving back-to-back AR issue without a bubble.
    if (req_fire) begin
      ar_valid_d = 1'b1;
      ar_addr_d  = mem_req_addr;
      ar_tag_d   = mem_req_tag;
    end else if (m_axi_arready) begin
      ar_valid_d = 1'b0;
    end

    if (req_fire && !retire) begin
      pending_d = pending_q + CNT_WIDTH'(1);
    end else if (!req_fire && retire) begin
      pending_d = pending_q - CNT_WIDTH'(1);
    end

    if (r_fire && ((m_axi_rresp != 2'b00) || !m_axi_rlast || (pending_q == '0))) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_valid_q <= 1'b0;
      pending_q  <= '0;
      error_q    <= 1'b0;
    end else begin
      ar_valid_q <= ar_valid_d;
      pending_q  <= pending_d;
      error_q    <= error_d;
    end
  end

  // Payload is qualified by ar_valid_q and needs no reset.
  always_ff @(posedge clk) begin
    ar_addr_q <= ar_addr_d;
    ar_tag_q  <= ar_tag_d;
  end

  assign m_axi_arvalid  = ar_valid_q;
  assign m_axi_araddr   = AXI_AW'(ar_addr_q) << OFFS_BITS;
  assign m_axi_arid     = ar_tag_q;
  assign m_axi_arlen    = '0;
  assign m_axi_arsize   = 3'(OFFS_BITS);
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arlock   = '0;
  assign m_axi_arcache  = 4'b0011;
  assign m_axi_arprot   = '0;
  assign m_axi_arqos    = '0;
  assign m_axi_arregion = '0;

  assign mem_rsp_valid  = m_axi_rvalid;
  assign m_axi_rready   = mem_rsp_ready;
  assign mem_rsp_data   = m_axi_rdata;
  assign mem_rsp_tag    = m_axi_rid;

  assign pending_count  = pending_q;
  assign busy           = (pending_q != '0) || ar_valid_q;
  assign rsp_error      = error_q;

endmodule

// File: tb/tb_vx_mem_axi_read_bridge.sv
module tb_vx_mem_axi_read_bridge;

  localparam int DW   = 512;
  localparam int AW   = 16;
  localparam int TW   = 8;
  localparam int MAXP = 2;
  localparam int OFFS = 6;
  localparam int CW   = $clog2(MAXP+1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          req_valid, rsp_ready, arready, rvalid, rlast;
  logic [AW-1:0] req_addr;
  logic [TW-1:0] req_tag, rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;

  logic             mem_req_ready, mem_rsp_valid, m_axi_arvalid, m_axi_rready;
  logic [DW-1:0]    mem_rsp_data;
  logic [TW-1:0]    mem_rsp_tag, m_axi_arid;
  logic [AW+OFFS-1:0] m_axi_araddr;
  logic [7:0]       m_axi_arlen;
  logic [2:0]       m_axi_arsize, m_axi_arprot;
  logic [1:0]       m_axi_arburst, m_axi_arlock;
  logic [3:0]       m_axi_arcache, m_axi_arqos, m_axi_arregion;
  logic [CW-1:0]    pending_count;
  logic             busy, rsp_error;

  vx_mem_axi_read_bridge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .MAX_PENDING(MAXP)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(req_addr), .mem_req_tag(req_tag),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(rsp_ready),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arqos(m_axi_arqos), .m_axi_arregion(m_axi_arregion),
    .m_axi_rvalid(rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(rdata), .m_axi_rlast(rlast),
    .m_axi_rid(rid), .m_axi_rresp(rresp),
    .pending_count(pending_count), .busy(busy), .rsp_error(rsp_error)
  );

  int checks   = 0;
  int failures = 0;

  // Transaction-level reference: requests waiting to be issued on AR, reads
  // issued and awaiting data, outstanding count and sticky error flag.
  typedef struct packed { logic [AW-1:0] addr; logic [TW-1:0] tag; } req_t;
  req_t ar_q[$];
  req_t out_q[$];
  int   m_pend = 0;
  bit   m_err  = 1'b0;
  bit   m_acc, m_rf, m_ret;

  function automatic bit m_ready();
    return ((ar_q.size() == 0) || arready) && (m_pend < MAXP);
  endfunction

  function automatic logic [DW-1:0] datafn(logic [AW-1:0] a, logic [TW-1:0] t);
    logic [31:0] w;
    w = {a, 8'h5A, t} ^ 32'hA5C3_0F1E;
    return {16{w}};
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      ar_q.delete();
      out_q.delete();
      m_pend = 0;
      m_err  = 1'b0;
    end else begin
      m_acc = req_valid && m_ready();
      m_rf  = rvalid && rsp_ready;
      if (m_rf && ((rresp != 2'b00) || !rlast || (m_pend == 0))) m_err = 1'b1;
      m_ret = m_rf && rlast && (m_pend > 0);
      if (m_rf) begin
        for (int i = 0; i < out_q.size(); i++) begin
          if (out_q[i].tag == rid) begin
            out_q.delete(i);
            break;
          end
        end
      end
      if ((ar_q.size() != 0) && arready) out_q.push_back(ar_q.pop_front());
      if (m_acc) ar_q.push_back({req_addr, req_tag});
      m_pend = m_pend + int'(m_acc) - int'(m_ret);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_addr = '0; req_tag = '0;
    rsp_ready = 1'b0; arready = 1'b0;
    rvalid = 1'b0; rdata = '0; rlast = 1'b0; rid = '0; rresp = 2'b00;
  endtask

  task automatic test_reset();
    logic [5:0] st;
    reset = 1'b1;
    idle();
    step();
    step();
    @(negedge clk);
    st = {m_axi_arvalid, mem_req_ready, busy, pending_count, rsp_error};
    checks++;
    if (st !== 6'b010_00_0) begin
      failures++;
      $display("FAIL reset_status got=%b exp=%b", st, 6'b010_00_0);
    end
    checks++;
    if ({m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache,
         m_axi_arprot, m_axi_arqos, m_axi_arregion} !== {8'd0, 3'd6, 2'b01, 2'b00, 4'b0011, 3'd0, 4'd0, 4'd0}) begin
      failures++;
      $display("FAIL ar_const_fields got len=%0d size=%0d burst=%0d cache=%0d exp len=0 size=6 burst=1 cache=3",
               m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    d = datafn(16'h0010, 8'd5);
    req_valid = 1'b1; req_addr = 16'h0010; req_tag = 8'd5;
    @(negedge clk);
    checks++;
    if (mem_req_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", mem_req_ready); end
    step();
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_axi_arvalid, m_axi_araddr, m_axi_arid, pending_count, busy} !== {1'b1, 22'h400, 8'd5, 2'd1, 1'b1}) begin
      failures++;
      $display("FAIL single_ar got v=%b addr=%0h id=%0d pend=%0d busy=%b exp v=1 addr=400 id=5 pend=1 busy=1",
               m_axi_arvalid, m_axi_araddr, m_axi_arid, pending_count, busy);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    @(negedge clk);
    checks++;
    if (m_axi_arvalid !== 1'b0) begin failures++; $display("FAIL single_ar_drop got=%b exp=0", m_axi_arvalid); end
    step();
    rvalid = 1'b1; rid = 8'd5; rlast = 1'b1; rresp = 2'b00; rdata = d; rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_rsp_valid, m_axi_rready, mem_rsp_tag} !== {1'b1, 1'b1, 8'd5} || mem_rsp_data !== d) begin
      failures++;
      $display("FAIL single_rsp got v=%b rdy=%b tag=%0d data_ok=%b exp v=1 rdy=1 tag=5 data_ok=1",
               mem_rsp_valid, m_axi_rready, mem_rsp_tag, mem_rsp_data === d);
    end
    step();
    rvalid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({pending_count, busy, rsp_error} !== {2'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL single_done got pend=%0d busy=%b err=%b exp 0 0 0", pending_count, busy, rsp_error);
    end
    step();
  endtask

  task automatic test_backpressure();
    arready = 1'b0;
    req_valid = 1'b1; req_addr = 16'h1234; req_tag = 8'd1;
    step();
    req_addr = 16'h0777; req_tag = 8'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({m_axi_arvalid, m_axi_araddr, m_axi_arid, mem_req_ready} !== {1'b1, 16'h1234, 6'b0, 8'd1, 1'b0}) begin
        failures++;
        $display("FAIL bp_stall cyc=%0d got v=%b addr=%0h id=%0d rdy=%b exp v=1 addr=48d00 id=1 rdy=0",
                 i, m_axi_arvalid, m_axi_araddr, m_axi_arid, mem_req_ready);
      end
      step();
    end
    arready = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", mem_req_ready); end
    step();
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_axi_arvalid, m_axi_araddr, m_axi_arid, pending_count} !== {1'b1, 16'h0777, 6'b0, 8'd2, 2'd2}) begin
      failures++;
      $display("FAIL bp_second got v=%b addr=%0h id=%0d pend=%0d exp v=1 addr=1ddc0 id=2 pend=2",
               m_axi_arvalid, m_axi_araddr, m_axi_arid, pending_count);
    end
    step();
    arready = 1'b0;
    rvalid = 1'b1; rid = 8'd2; rlast = 1'b1; rresp = 2'b00; rsp_ready = 1'b1;
    step();
    rid = 8'd1;
    step();
    rvalid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({pending_count, rsp_error, m_axi_arvalid} !== {2'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL bp_drain got pend=%0d err=%b v=%b exp 0 0 0", pending_count, rsp_error, m_axi_arvalid);
    end
    step();
  endtask

  task automatic test_full();
    arready = 1'b1;
    req_valid = 1'b1; req_addr = 16'(($urandom)); req_tag = 8'd10;
    step();
    req_addr = 16'($urandom); req_tag = 8'd11;
    step();
    req_addr = 16'($urandom); req_tag = 8'd12;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_req_ready, pending_count} !== {1'b0, 2'd2}) begin
        failures++;
        $display("FAIL full_stall cyc=%0d got rdy=%b pend=%0d exp rdy=0 pend=2", i, mem_req_ready, pending_count);
      end
      step();
    end
    rvalid = 1'b1; rid = 8'd10; rlast = 1'b1; rresp = 2'b00; rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req_ready, pending_count} !== {1'b0, 2'd2}) begin
      failures++;
      $display("FAIL full_retire_cycle got rdy=%b pend=%0d exp rdy=0 pend=2", mem_req_ready, pending_count);
    end
    step();
    rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req_ready, pending_count} !== {1'b1, 2'd1}) begin
      failures++;
      $display("FAIL full_reopen got rdy=%b pend=%0d exp rdy=1 pend=1", mem_req_ready, pending_count);
    end
    step();
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({pending_count, m_axi_arvalid, m_axi_arid} !== {2'd2, 1'b1, 8'd12}) begin
      failures++;
      $display("FAIL full_third got pend=%0d v=%b id=%0d exp pend=2 v=1 id=12", pending_count, m_axi_arvalid, m_axi_arid);
    end
    step();
    rvalid = 1'b1; rid = 8'd11;
    step();
    rid = 8'd12;
    step();
    rvalid = 1'b0; rsp_ready = 1'b0; arready = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    arready = 1'b1;
    req_valid = 1'b1; req_addr = 16'h00AA; req_tag = 8'd20;
    step();
    req_valid = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if ({pending_count, m_axi_arvalid} !== {2'd1, 1'b0}) begin
      failures++;
      $display("FAIL simul_setup got pend=%0d v=%b exp pend=1 v=0", pending_count, m_axi_arvalid);
    end
    req_valid = 1'b1; req_addr = 16'h00BB; req_tag = 8'd21;
    rvalid = 1'b1; rid = 8'd20; rlast = 1'b1; rresp = 2'b00; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({pending_count, m_axi_arvalid, m_axi_arid} !== {2'd1, 1'b1, 8'd21}) begin
      failures++;
      $display("FAIL simul_count got pend=%0d v=%b id=%0d exp pend=1 v=1 id=21", pending_count, m_axi_arvalid, m_axi_arid);
    end
    step();
    rvalid = 1'b1; rid = 8'd21;
    step();
    rvalid = 1'b0; rsp_ready = 1'b0; arready = 1'b0;
    @(negedge clk);
    checks++;
    if ({pending_count, busy, rsp_error} !== {2'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL simul_drain got pend=%0d busy=%b err=%b exp 0 0 0", pending_count, busy, rsp_error);
    end
    step();
  endtask

  task automatic test_errors();
    logic [5:0] st;
    // Spurious beat with nothing outstanding.
    rvalid = 1'b1; rid = 8'd3; rlast = 1'b1; rresp = 2'b00; rsp_ready = 1'b1;
    step();
    rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({pending_count, rsp_error} !== {2'd0, 1'b1}) begin
      failures++;
      $display("FAIL err_spurious got pend=%0d err=%b exp pend=0 err=1", pending_count, rsp_error);
    end
    step(); step(); step();
    @(negedge clk);
    checks++;
    if (rsp_error !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", rsp_error); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_error !== 1'b0) begin failures++; $display("FAIL err_reset_clear got=%b exp=0", rsp_error); end
    // Slave error response.
    arready = 1'b1;
    req_valid = 1'b1; req_addr = 16'h0042; req_tag = 8'd30;
    step();
    req_valid = 1'b0;
    step();
    rvalid = 1'b1; rid = 8'd30; rlast = 1'b1; rresp = 2'b10;
    step();
    rvalid = 1'b0; rresp = 2'b00;
    step(); step();
    @(negedge clk);
    checks++;
    if ({pending_count, rsp_error} !== {2'd0, 1'b1}) begin
      failures++;
      $display("FAIL err_slverr got pend=%0d err=%b exp pend=0 err=1", pending_count, rsp_error);
    end
    // Reset with a request still held in the AR register.
    reset = 1'b1;
    step();
    reset = 1'b0;
    arready = 1'b0;
    req_valid = 1'b1; req_addr = 16'h0099; req_tag = 8'd40;
    step();
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_axi_arvalid, busy, pending_count} !== {1'b1, 1'b1, 2'd1}) begin
      failures++;
      $display("FAIL err_inflight got v=%b busy=%b pend=%0d exp v=1 busy=1 pend=1", m_axi_arvalid, busy, pending_count);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    st = {m_axi_arvalid, mem_req_ready, busy, pending_count, rsp_error};
    checks++;
    if (st !== 6'b010_00_0) begin
      failures++;
      $display("FAIL err_midreset got=%b exp=%b", st, 6'b010_00_0);
    end
    rvalid = 1'b1; rid = 8'd40; rlast = 1'b1;
    step();
    rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({pending_count, rsp_error} !== {2'd0, 1'b1}) begin
      failures++;
      $display("FAIL err_late_beat got pend=%0d err=%b exp pend=0 err=1", pending_count, rsp_error);
    end
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_stream();
    logic [AW-1:0] exp_addr [256];
    int ret_cnt [256];
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    int idx;
    int bad  = 0;
    logic [DW-1:0] ed;
    for (int i = 0; i < 256; i++) begin ret_cnt[i] = 0; exp_addr[i] = '0; end
    while (got < 100 && cyc < 6000) begin
      if (!(rvalid && !rsp_ready)) begin
        if (out_q.size() > 0 && $urandom_range(0, 1) == 1) begin
          idx    = $urandom_range(0, out_q.size() - 1);
          rvalid = 1'b1;
          rid    = out_q[idx].tag;
          rdata  = datafn(out_q[idx].addr, out_q[idx].tag);
          rlast  = 1'b1;
          rresp  = 2'b00;
        end else begin
          rvalid = 1'b0;
        end
      end
      req_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
      req_addr  = 16'($urandom);
      req_tag   = TW'(sent);
      arready   = ($urandom_range(0, 2) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      checks++;
      if ({32'(pending_count), mem_req_ready, m_axi_arvalid, rsp_error} !==
          {32'(m_pend), m_ready(), ar_q.size() != 0, m_err}) begin
        failures++;
        $display("FAIL stream_state cyc=%0d got pend=%0d rdy=%b v=%b err=%b exp pend=%0d rdy=%b v=%b err=%b",
                 cyc, pending_count, mem_req_ready, m_axi_arvalid, rsp_error,
                 m_pend, m_ready(), ar_q.size() != 0, m_err);
      end
      checks++;
      if (32'(pending_count) > MAXP) begin
        failures++;
        $display("FAIL stream_maxpend got=%0d exp<=%0d", pending_count, MAXP);
      end
      if (m_axi_arvalid && ar_q.size() != 0) begin
        checks++;
        if ({m_axi_araddr, m_axi_arid} !== {ar_q[0].addr, 6'b0, ar_q[0].tag}) begin
          failures++;
          $display("FAIL stream_ar got addr=%0h id=%0d exp addr=%0h id=%0d",
                   m_axi_araddr, m_axi_arid, {ar_q[0].addr, 6'b0}, ar_q[0].tag);
        end
      end
      if (req_valid && m_ready()) begin
        exp_addr[req_tag] = req_addr;
        sent++;
      end
      if (rvalid && rsp_ready) begin
        ed = datafn(exp_addr[rid], rid);
        checks++;
        if (mem_rsp_valid !== 1'b1 || mem_rsp_tag !== rid || mem_rsp_data !== ed) begin
          failures++;
          $display("FAIL stream_rsp got v=%b tag=%0d data_ok=%b exp v=1 tag=%0d data_ok=1",
                   mem_rsp_valid, mem_rsp_tag, mem_rsp_data === ed, rid);
        end
        ret_cnt[rid]++;
        got++;
      end
      step();
      cyc++;
    end
    idle();
    checks++;
    if (got < 100) begin
      failures++;
      $display("FAIL stream_timeout got=%0d responses exp=100", got);
    end
    for (int t = 0; t < 256; t++) begin
      if (ret_cnt[t] != ((t < 100) ? 1 : 0)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stream_tags_once got bad_tags=%0d exp=0", bad);
    end
    step();
    @(negedge clk);
    checks++;
    if ({pending_count, busy} !== {2'd0, 1'b0}) begin
      failures++;
      $display("FAIL stream_end got pend=%0d busy=%b exp 0 0", pending_count, busy);
    end
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_full();
    test_simultaneous();
    test_errors();
    test_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
